// File: rtl/amba3_apb_arbiter.sv
// amba3_apb_arbiter: round-robin sharing of one AMBA 3 APB master port among NUM_REQ requesters
module amba3_apb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int TIMEOUT   = 0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             resp_done,
  output logic                           resp_err,
  output logic [DATA_SIZE-1:0]           resp_rdata,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic [ADDR_SIZE-1:0]           paddr,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [DATA_SIZE-1:0]           pwdata,
  input  logic                           pready,
  input  logic [DATA_SIZE-1:0]           prdata
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d, gid_q, gid_d, pick;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]  paddr_q, paddr_d;
  logic [DATA_SIZE-1:0]  pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic                  pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d, err_q, err_d;
  logic [NUM_REQ-1:0]    done_q, done_d, elig;
  logic [IW:0]           sum;
  logic                  found, abort;
  assign elig  = req_valid & ~done_q;
  assign abort = TIMEOUT > 0 && !pready && cnt_q == CW'(TIMEOUT - 1);
  // first eligible requester at or above the round-robin pointer, wrapping
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      sum = sum >= (IW+1)'(NUM_REQ) ? sum - (IW+1)'(NUM_REQ) : sum;
      if (!found && elig[sum[IW-1:0]]) begin
        pick  = sum[IW-1:0];
        found = 1'b1;
      end
    end
  end
  // APB setup/access sequencing, completion and watchdog abort
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gid_d     = gid_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    done_d    = '0;
    err_d     = 1'b0;
    rdata_d   = '0;
    case (state_q)
      IDLE: if (found) begin
        state_d  = SETUP;
        gid_d    = pick;
        paddr_d  = req_addr[pick*ADDR_SIZE +: ADDR_SIZE];
        pwrite_d = req_write[pick];
        pwdata_d = req_write[pick] ? req_wdata[pick*DATA_SIZE +: DATA_SIZE] : '0;
        psel_d   = 1'b1;
        cnt_d    = '0;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: if (pready || abort) begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        paddr_d   = '0;
        pwrite_d  = 1'b0;
        pwdata_d  = '0;
        done_d    = NUM_REQ'(1) << gid_q;
        err_d     = abort;
        rdata_d   = pready && !pwrite_q ? prdata : '0;
        ptr_d     = gid_q == IW'(NUM_REQ - 1) ? '0 : gid_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gid_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gid_q     <= gid_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end
  assign resp_done  = done_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign grant_id   = gid_q;
  assign paddr      = paddr_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign pwdata     = pwdata_q;
endmodule

// File: tb/tb_amba3_apb_arbiter.sv
// tb_amba3_apb_arbiter: randomized requesters and slave checked against a transaction-level model
module tb_amba3_apb_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;
  logic          clk = 1'b0, preset = 1'b1;
  logic [N-1:0]  rv = '0, rw = '0;
  logic [N*32-1:0] ra = '0, rwd = '0;
  logic [N-1:0]  resp_done;
  logic          resp_err;
  logic [31:0]   resp_rdata, paddr, pwdata, prdata = '0;
  logic [1:0]    grant_id;
  logic          psel, penable, pwrite, pready = 1'b0, stall = 1'b0;
  int            vecs = 0, errs = 0, cyc = 0, nres = 0;
  int            m_ph = 0, m_g = 0, m_cnt = 0, m_ptr = 0;
  logic [N-1:0]  m_mask = '0, elig;
  logic [31:0]   m_addr = '0, m_wdata = '0;
  logic          m_wr = 1'b0, hit;
  typedef struct {int cyc; logic [N-1:0] done; logic err; logic [31:0] rdata;} resp_t;
  resp_t         q[$];

  amba3_apb_arbiter #(.NUM_REQ(N), .ADDR_SIZE(32), .DATA_SIZE(32), .TIMEOUT(TO)) dut (
    .pclk(clk), .preset(preset), .req_valid(rv), .req_write(rw), .req_addr(ra), .req_wdata(rwd),
    .resp_done(resp_done), .resp_err(resp_err), .resp_rdata(resp_rdata), .grant_id(grant_id),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic new_cmd(input int i);
    rv[i] = 1'b1;
    rw[i] = 1'($urandom % 2);
    ra[i*32 +: 32] = $urandom;
    rwd[i*32 +: 32] = $urandom;
  endtask

  // reference model: phase 0 = bus free, 1 = setup, 2 = access; checks APB pins then advances
  always @(negedge clk) begin
    if (m_ph == 0) begin
      chk("psel_idle", psel, 0);
      chk("penable_idle", penable, 0);
      chk("paddr_idle", paddr, 0);
      chk("pwdata_idle", pwdata, 0);
      chk("pwrite_idle", pwrite, 0);
    end else begin
      chk("psel", psel, 1);
      chk("penable", penable, m_ph == 2);
      chk("grant_id", grant_id, m_g);
      chk("paddr", paddr, m_addr);
      chk("pwrite", pwrite, m_wr);
      chk("pwdata", pwdata, m_wdata);
    end
    if (preset) begin
      m_ph = 0; m_ptr = 0; m_mask = '0; m_cnt = 0;
    end else begin
      elig = rv & ~m_mask;
      m_mask = '0;
      if (m_ph == 0) begin
        hit = 1'b0;
        for (int k = 0; k < N; k++)
          if (!hit && elig[(m_ptr + k) % N]) begin
            hit = 1'b1;
            m_g = (m_ptr + k) % N;
          end
        if (hit) begin
          m_addr  = ra[m_g*32 +: 32];
          m_wr    = rw[m_g];
          m_wdata = m_wr ? rwd[m_g*32 +: 32] : 32'h0;
          m_ph    = 1;
          m_cnt   = 0;
        end
      end else if (m_ph == 1) begin
        m_ph = 2;
      end else if (pready || m_cnt == TO - 1) begin
        q.push_back('{cyc + 1, N'(1) << m_g, !pready, (pready && !m_wr) ? prdata : 32'h0});
        m_mask = N'(1) << m_g;
        m_ptr  = (m_g + 1) % N;
        m_ph   = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  // response monitor: the scoreboard head is due exactly in its stamped cycle
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      chk("resp_done", resp_done, q[0].done);
      chk("resp_err", resp_err, q[0].err);
      chk("resp_rdata", resp_rdata, q[0].rdata);
      void'(q.pop_front());
    end else begin
      chk("no_done", resp_done, 0);
      chk("no_err", resp_err, 0);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_rdata", resp_rdata, 0);
    @(posedge clk);
    #1 preset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      preset = 1'b0;
      stall  = (c % 500) > 430;
      pready = stall ? 1'b0 : ($urandom % 3 != 0);
      prdata = $urandom;
      if (!stall && m_ph == 2 && nres < 6 && $urandom % 40 == 0) begin
        preset = 1'b1;
        nres++;
      end
      for (int i = 0; i < N; i++) begin
        if (m_mask[i]) begin
          if ($urandom % 2 == 1) new_cmd(i);
          else rv[i] = 1'b0;
        end else if (!rv[i]) begin
          if ($urandom % 4 == 0) new_cmd(i);
        end else if (!(m_ph != 0 && m_g == i) && $urandom % 40 == 0) begin
          rv[i] = 1'b0;
        end
      end
    end
    rv = '0;
    pready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/amba3_apb_arbiter.md
Name: amba3_apb_arbiter

Overview:
- Shares one AMBA 3 APB master port between NUM_REQ local requesters.
- Each requester uses a simple valid/done command interface; round-robin arbitration selects one requester.
- The arbiter drives the APB setup/access sequence, waits on pready and returns read data plus a completion pulse.
- An optional watchdog aborts transfers stalled on pready. Sits between bus-master agents (DMA, CPU bridge, test sequencers) and an APB interconnect/slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ADDR_SIZE, 32, APB address width
- DATA_SIZE, 32, APB data width
- TIMEOUT, 0, max ACCESS cycles waiting for pready before abort; 0 disables watchdog

Ports:
- pclk  in  1  APB clock, all logic on rising edge
- preset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester command pending; held high with fields stable until its resp_done
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_SIZE  packed addresses, requester i at [i*ADDR_SIZE +: ADDR_SIZE]
- req_wdata  in  NUM_REQ*DATA_SIZE  packed write data
- resp_done  out  NUM_REQ  one-cycle completion pulse, one-hot
- resp_err  out  1  valid with resp_done; 1 = watchdog abort
- resp_rdata  out  DATA_SIZE  read data, valid with resp_done (0 for writes/aborts)
- grant_id  out  $clog2(NUM_REQ)  index of requester owning the bus (valid while psel=1)
- paddr  out  ADDR_SIZE  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_SIZE  APB write data
- pready  in  1  APB slave ready
- prdata  in  DATA_SIZE  APB read data

Behaviour:
- One clock: pclk. Reset preset is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - psel, penable, pwrite = 0; paddr, pwdata = 0
  - resp_done = 0, resp_err = 0, resp_rdata = 0, grant_id = 0
  - state = IDLE, round-robin pointer = 0, watchdog counter = 0
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible set = req_valid & ~resp_done. This masks a requester in the same cycle its done pulse is visible.
  - If eligible is nonzero: pick the first set bit searching from pointer upward with wrap.
  - Latch grant_id, paddr, pwrite, and pwdata (pwdata = 0 for reads). Go to SETUP.
  - Next cycle: psel=1, penable=0.
  - If eligible is zero: stay in IDLE.
- SETUP: always advances to ACCESS; penable=1 next cycle. Address, direction and data stay stable.
- ACCESS, pready=1 at the edge:
  - Next cycle: psel=0, penable=0, paddr/pwrite/pwdata=0.
  - resp_done[grant_id]=1; resp_rdata = prdata if read, else 0; resp_err=0.
  - pointer = grant_id+1 mod NUM_REQ. Go to IDLE.
- ACCESS, pready=0: stay in ACCESS; watchdog counter increments.
- Watchdog abort (TIMEOUT>0, counter reaches TIMEOUT with pready still 0):
  - Same exit as a completion, but resp_err=1 and resp_rdata=0.
  - Pointer still advances.
- The watchdog counter clears on entering SETUP.
- resp_done and resp_err are high for exactly one cycle (the IDLE cycle following completion).
- Latency: grant decision in IDLE cycle T; SETUP at T+1; ACCESS at T+2. With pready=1 at T+2, resp_done at T+3.
- Back-to-back throughput: 3 cycles per zero-wait transfer (SETUP, ACCESS, IDLE+arbitrate).
- Requester fields are sampled only in IDLE. Changes during SETUP/ACCESS are ignored.
- A requester that drops req_valid before being granted is simply not granted. It receives no done pulse.
- Simultaneous requests: lowest index at or above pointer wins. After reset, req0 has highest priority.
- Reset mid-transfer:
  - Synchronous preset returns to IDLE with reset values on the next edge.
  - No resp_done is issued for the aborted transfer; pointer returns to 0.
- grant_id holds its last value in IDLE (don't-care when psel=0).

Test Plan:
- Single write: req_valid[1]=1, addr=0x0000_0010, wdata=0xDEAD_BEEF, pready tied 1 -> psel at T+1, penable at T+2 with paddr=0x10, pwdata=0xDEADBEEF, pwrite=1; resp_done=4'b0010 at T+3, resp_err=0.
- Read with wait states: req0 read addr 0x20, pready low for 3 ACCESS cycles, then high with prdata=0x1234_5678 -> ACCESS lasts 4 cycles; resp_done[0]=1 with resp_rdata=0x12345678 one cycle after.
- Round-robin fairness: all 4 requesters valid continuously, each reasserting after done, pready=1 -> grant order 0,1,2,3,0,1, one grant per 3 cycles; no requester granted twice consecutively.
- Watchdog: TIMEOUT=8, req2 read, pready held 0 -> psel/penable drop after 8 ACCESS cycles; resp_done=4'b0100, resp_err=1, resp_rdata=0; the next request proceeds normally.
- Reset mid-operation: assert preset for 1 cycle during ACCESS of req3 -> next cycle psel=penable=0, paddr=0, no resp_done pulse; with req1 and req3 valid afterwards, req1 is granted first (pointer=0).
- Drop before grant: req0 busy, req1 valid for 1 cycle then low before IDLE -> req1 never granted, no resp_done[1], APB idles after req0 completes.
